// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, per-stage stall vectors and the stall-merge helper.
// Stall vector bit order is {wb, mem, ex, id, if, pc}.
// Bubble vector bit order is {wb, mem, ex, id}.
package pipeline_hazard_ctrl_pkg;

   localparam logic [1:0] RUN        = 2'd0;
   localparam logic [1:0] EXC_WAIT   = 2'd1;
   localparam logic [1:0] FLUSH      = 2'd2;
   localparam logic [1:0] REDIR_HOLD = 2'd3;

   localparam logic [5:0] STALL_NONE  = 6'b000000;
   localparam logic [5:0] STALL_IF    = 6'b000011;
   localparam logic [5:0] STALL_ID    = 6'b000111;
   localparam logic [5:0] STALL_EX    = 6'b001111;
   localparam logic [5:0] STALL_MEM   = 6'b011111;
   localparam logic [5:0] STALL_REDIR = 6'b000010;

   localparam logic [3:0] BUBBLE_NONE = 4'b0000;
   localparam logic [3:0] BUBBLE_ID   = 4'b0001;
   localparam logic [3:0] BUBBLE_EX   = 4'b0010;
   localparam logic [3:0] BUBBLE_MEM  = 4'b0100;
   localparam logic [3:0] BUBBLE_WB   = 4'b1000;

   typedef struct packed {
      logic [5:0] stall;
      logic [3:0] bubble;
   } stall_ctrl_t;

   // The latest requesting stage wins: it and everything before it hold,
   // and the stage after it is fed a NOP.
   function automatic stall_ctrl_t merge_stall(input logic req_if, input logic req_id,
                                               input logic req_ex, input logic req_mem);
      stall_ctrl_t c;
      c = '{stall: STALL_NONE, bubble: BUBBLE_NONE};
      if (req_mem) begin
         c = '{stall: STALL_MEM, bubble: BUBBLE_WB};
      end else if (req_ex) begin
         c = '{stall: STALL_EX, bubble: BUBBLE_MEM};
      end else if (req_id) begin
         c = '{stall: STALL_ID, bubble: BUBBLE_EX};
      end else if (req_if) begin
         c = '{stall: STALL_IF, bubble: BUBBLE_ID};
      end
      return c;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard
// controller (slave): stall requests and exception in, stage controls out.
interface pipeline_hazard_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  request_from_if;
   logic                  request_from_id;
   logic                  request_from_ex;
   logic                  request_from_mem;
   logic                  exc_valid;
   logic [ADDR_WIDTH-1:0] exc_target;

   logic                  stall_pc;
   logic                  stall_if;
   logic                  stall_id;
   logic                  stall_ex;
   logic                  stall_mem;
   logic                  stall_wb;
   logic                  bubble_id;
   logic                  bubble_ex;
   logic                  bubble_mem;
   logic                  bubble_wb;
   logic                  flush_all;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_addr;
   logic                  stall_timeout;

   modport master (
      output request_from_if, request_from_id, request_from_ex, request_from_mem,
      output exc_valid, exc_target,
      input  stall_pc, stall_if, stall_id, stall_ex, stall_mem, stall_wb,
      input  bubble_id, bubble_ex, bubble_mem, bubble_wb,
      input  flush_all, redirect_valid, redirect_addr, stall_timeout
   );

   modport slave (
      input  request_from_if, request_from_id, request_from_ex, request_from_mem,
      input  exc_valid, exc_target,
      output stall_pc, stall_if, stall_id, stall_ex, stall_mem, stall_wb,
      output bubble_id, bubble_ex, bubble_mem, bubble_wb,
      output flush_all, redirect_valid, redirect_addr, stall_timeout
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_stall_watchdog.sv
// Consecutive-stall watchdog: counts cycles with the PC held, pulses once
// when the count reaches STALL_TIMEOUT, then saturates until the stall ends.
module pipeline_hazard_ctrl_stall_watchdog #(
   parameter int TO_WIDTH      = 16,
   parameter int STALL_TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic i_stall,
   output logic o_timeout
);
   localparam logic [TO_WIDTH-1:0] LP_LIMIT = TO_WIDTH'(STALL_TIMEOUT);
   localparam logic [TO_WIDTH-1:0] LP_LAST  = TO_WIDTH'(STALL_TIMEOUT - 1);
   localparam logic [TO_WIDTH-1:0] LP_ONE   = TO_WIDTH'(1);

   logic [TO_WIDTH-1:0] r_count;

   // Count consecutive stall cycles, clear on any free cycle, hold at the limit.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      if (!rst) begin
         r_count <= '0;
      end else if (!i_stall) begin
         r_count <= '0;
      end else if (r_count != LP_LIMIT) begin
         r_count <= r_count + LP_ONE;
      end
   end

   // The cycle that takes the count to the limit is the pulse cycle.
   assign o_timeout = i_stall && (r_count == LP_LAST);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: merges stage stall requests, sequences
// exception flush and PC redirect around memory and fetch waits, and
// watches for runaway stalls.
// Optional: define PIPE_PERF_CNT_EN to add stall-cycle and flush counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH    = 32,
   parameter int TO_WIDTH      = 16,
   parameter int STALL_TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   pipeline_hazard_ctrl_if.slave hz
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0]           perf_stall_cycles,
   output logic [31:0]           perf_flush_count
`endif
);
   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic                  w_capture;
   logic [ADDR_WIDTH-1:0] r_redirect_addr;
   stall_ctrl_t           w_merge;
   stall_ctrl_t           w_ctrl;
   logic                  w_flush;
   logic                  w_redir;
   logic                  w_timeout;

   assign w_merge = merge_stall(hz.request_from_if, hz.request_from_id,
                                hz.request_from_ex, hz.request_from_mem);

   // Sequence exception handling; exceptions are only accepted in RUN.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a latch.
      w_next_state = r_state;
      w_capture    = 1'b0;
      case (r_state)
         RUN: begin
            if (hz.exc_valid) begin
               w_capture    = 1'b1;
               w_next_state = hz.request_from_mem ? EXC_WAIT : FLUSH;
            end
         end
         EXC_WAIT:   if (!hz.request_from_mem) w_next_state = FLUSH;
         FLUSH:      w_next_state = hz.request_from_if ? REDIR_HOLD : RUN;
         REDIR_HOLD: if (!hz.request_from_if) w_next_state = RUN;
         default:    w_next_state = RUN;
      endcase
   end

   // Stage controls per state; everything is forced low while reset is held.
   always_comb begin
      w_ctrl  = '{stall: STALL_NONE, bubble: BUBBLE_NONE};
      w_flush = 1'b0;
      w_redir = 1'b0;
      case (r_state)
         RUN:        w_ctrl = w_merge;
         EXC_WAIT:   w_ctrl = '{stall: STALL_MEM, bubble: BUBBLE_WB};
         FLUSH: begin
            w_flush = 1'b1;
            w_redir = 1'b1;
         end
         REDIR_HOLD: begin
            w_redir      = 1'b1;
            w_ctrl.stall = STALL_REDIR;
         end
         default: ;
      endcase
      // Reset is asynchronous, so outputs must drop without waiting for a clock.
      if (!rst) begin
         w_ctrl  = '{stall: STALL_NONE, bubble: BUBBLE_NONE};
         w_flush = 1'b0;
         w_redir = 1'b0;
      end
   end

   // FSM state and latched handler address.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state         <= RUN;
         r_redirect_addr <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_capture) r_redirect_addr <= hz.exc_target;
      end
   end

   pipeline_hazard_ctrl_stall_watchdog #(
      .TO_WIDTH      (TO_WIDTH),
      .STALL_TIMEOUT (STALL_TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .i_stall   (w_ctrl.stall[0]),
      .o_timeout (w_timeout)
   );

   assign hz.stall_pc       = w_ctrl.stall[0];
   assign hz.stall_if       = w_ctrl.stall[1];
   assign hz.stall_id       = w_ctrl.stall[2];
   assign hz.stall_ex       = w_ctrl.stall[3];
   assign hz.stall_mem      = w_ctrl.stall[4];
   assign hz.stall_wb       = w_ctrl.stall[5];
   assign hz.bubble_id      = w_ctrl.bubble[0];
   assign hz.bubble_ex      = w_ctrl.bubble[1];
   assign hz.bubble_mem     = w_ctrl.bubble[2];
   assign hz.bubble_wb      = w_ctrl.bubble[3];
   assign hz.flush_all      = w_flush;
   assign hz.redirect_valid = w_redir;
   assign hz.redirect_addr  = w_redir ? r_redirect_addr : '0;
   assign hz.stall_timeout  = w_timeout;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;

   // Free-running performance counters; they wrap naturally at 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_stall <= '0;
         r_perf_flush <= '0;
      end else begin
         if (w_ctrl.stall[0]) r_perf_stall <= r_perf_stall + 32'd1;
         if (r_state == FLUSH) r_perf_flush <= r_perf_flush + 32'd1;
      end
   end

   assign perf_stall_cycles = r_perf_stall;
   assign perf_flush_count  = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with STALL_TIMEOUT=4.
// Control outputs are packed as {stall wb..pc, bubble wb..id, flush, redirect_valid, timeout}.
module tb_pipeline_hazard_ctrl;

   localparam int AW = 32;
   localparam int NV = 26;

   typedef struct {
      logic [3:0]  req;      // {mem, ex, id, if}
      logic        exc;
      logic [31:0] tgt;
      logic [12:0] exp_ctl;
      logic [31:0] exp_addr;
   } vec_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   vec_t vecs [NV];

   pipeline_hazard_ctrl_if #(.ADDR_WIDTH(AW)) hz ();

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flush_count;
`endif

   pipeline_hazard_ctrl #(
      .ADDR_WIDTH    (AW),
      .TO_WIDTH      (16),
      .STALL_TIMEOUT (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
`ifdef PIPE_PERF_CNT_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flush_count  (perf_flush_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] ctl(input logic [5:0] st, input logic [3:0] bb,
                                       input logic fl, input logic rv, input logic to);
      return {st, bb, fl, rv, to};
   endfunction

   function automatic vec_t mk(input logic [3:0] req, input logic exc, input logic [31:0] tgt,
                               input logic [12:0] ec, input logic [31:0] ea);
      vec_t v;
      v.req = req; v.exc = exc; v.tgt = tgt; v.exp_ctl = ec; v.exp_addr = ea;
      return v;
   endfunction

   function automatic logic [12:0] get_ctl();
      return {hz.stall_wb, hz.stall_mem, hz.stall_ex, hz.stall_id, hz.stall_if, hz.stall_pc,
              hz.bubble_wb, hz.bubble_mem, hz.bubble_ex, hz.bubble_id,
              hz.flush_all, hz.redirect_valid, hz.stall_timeout};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] req, input logic exc, input logic [31:0] tgt);
      hz.request_from_mem = req[3];
      hz.request_from_ex  = req[2];
      hz.request_from_id  = req[1];
      hz.request_from_if  = req[0];
      hz.exc_valid        = exc;
      hz.exc_target       = tgt;
   endtask

   // One clock cycle: new inputs just after the rising edge, outputs sampled on the falling edge.
   task automatic cyc(input logic [3:0] req, input logic exc, input logic [31:0] tgt);
      @(posedge clk);
      #1;
      drive(req, exc, tgt);
      @(negedge clk);
   endtask

   localparam logic [5:0] S_NO = 6'b000000, S_IF = 6'b000011, S_ID = 6'b000111,
                          S_EX = 6'b001111, S_MEM = 6'b011111, S_HOLD = 6'b000010;
   localparam logic [3:0] B_NO = 4'b0000, B_ID = 4'b0001, B_EX = 4'b0010,
                          B_MEM = 4'b0100, B_WB = 4'b1000;

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Single-cycle merge cases, then exception sequences with waits.
      vecs[0]  = mk(4'b0000, 0, 32'h0,        ctl(S_NO,  B_NO,  0, 0, 0), 32'h0);
      vecs[1]  = mk(4'b0010, 0, 32'h0,        ctl(S_ID,  B_EX,  0, 0, 0), 32'h0);
      vecs[2]  = mk(4'b0000, 0, 32'h0,        ctl(S_NO,  B_NO,  0, 0, 0), 32'h0);
      vecs[3]  = mk(4'b0101, 0, 32'h0,        ctl(S_EX,  B_MEM, 0, 0, 0), 32'h0);
      vecs[4]  = mk(4'b1010, 0, 32'h0,        ctl(S_MEM, B_WB,  0, 0, 0), 32'h0);
      vecs[5]  = mk(4'b0001, 0, 32'h0,        ctl(S_IF,  B_ID,  0, 0, 0), 32'h0);
      vecs[6]  = mk(4'b0000, 0, 32'h0,        ctl(S_NO,  B_NO,  0, 0, 0), 32'h0);
      vecs[7]  = mk(4'b0000, 1, 32'hBFC00380, ctl(S_NO,  B_NO,  0, 0, 0), 32'h0);
      vecs[8]  = mk(4'b0000, 0, 32'h0,        ctl(S_NO,  B_NO,  1, 1, 0), 32'hBFC00380);
      vecs[9]  = mk(4'b0000, 0, 32'h0,        ctl(S_NO,  B_NO,  0, 0, 0), 32'h0);
      vecs[10] = mk(4'b0010, 1, 32'h80000180, ctl(S_ID,  B_EX,  0, 0, 0), 32'h0);
      vecs[11] = mk(4'b0010, 0, 32'h0,        ctl(S_NO,  B_NO,  1, 1, 0), 32'h80000180);
      vecs[12] = mk(4'b0000, 0, 32'h0,        ctl(S_NO,  B_NO,  0, 0, 0), 32'h0);
      vecs[13] = mk(4'b1000, 1, 32'h00000100, ctl(S_MEM, B_WB,  0, 0, 0), 32'h0);
      vecs[14] = mk(4'b1000, 1, 32'hDEAD0000, ctl(S_MEM, B_WB,  0, 0, 0), 32'h0);
      vecs[15] = mk(4'b1000, 0, 32'h0,        ctl(S_MEM, B_WB,  0, 0, 0), 32'h0);
      vecs[16] = mk(4'b1000, 0, 32'h0,        ctl(S_MEM, B_WB,  0, 0, 1), 32'h0);
      vecs[17] = mk(4'b0000, 0, 32'h0,        ctl(S_MEM, B_WB,  0, 0, 0), 32'h0);
      vecs[18] = mk(4'b0000, 0, 32'h0,        ctl(S_NO,  B_NO,  1, 1, 0), 32'h00000100);
      vecs[19] = mk(4'b0000, 0, 32'h0,        ctl(S_NO,  B_NO,  0, 0, 0), 32'h0);
      vecs[20] = mk(4'b0001, 1, 32'h00000200, ctl(S_IF,  B_ID,  0, 0, 0), 32'h0);
      vecs[21] = mk(4'b0001, 0, 32'h0,        ctl(S_NO,  B_NO,  1, 1, 0), 32'h00000200);
      vecs[22] = mk(4'b0001, 1, 32'hFFFF0000, ctl(S_HOLD, B_NO, 0, 1, 0), 32'h00000200);
      vecs[23] = mk(4'b0000, 0, 32'h0,        ctl(S_HOLD, B_NO, 0, 1, 0), 32'h00000200);
      vecs[24] = mk(4'b0000, 0, 32'h0,        ctl(S_NO,  B_NO,  0, 0, 0), 32'h0);
      vecs[25] = mk(4'b0000, 0, 32'h0,        ctl(S_NO,  B_NO,  0, 0, 0), 32'h0);

      // Reset held with requests active: every output must be low.
      rst = 1'b0;
      drive(4'b1111, 1'b1, 32'h12345678);
      #2;
      check("reset_ctl",  64'(get_ctl()), 64'(13'h0));
      check("reset_addr", 64'(hz.redirect_addr), 64'h0);
      #10;
      drive(4'b0000, 1'b0, 32'h0);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         cyc(vecs[i].req, vecs[i].exc, vecs[i].tgt);
         check($sformatf("vec%0d_ctl", i),  64'(get_ctl()), 64'(vecs[i].exp_ctl));
         check($sformatf("vec%0d_addr", i), 64'(hz.redirect_addr), 64'(vecs[i].exp_addr));
      end

      // Watchdog: ten MEM stall cycles, single pulse on the fourth.
      for (int k = 0; k < 10; k++) begin
         cyc(4'b1000, 1'b0, 32'h0);
         check($sformatf("wd_cycle%0d", k), 64'(get_ctl()),
               64'(ctl(S_MEM, B_WB, 0, 0, (k == 3))));
      end

      // Asynchronous reset in the middle of a stall drops outputs at once.
      @(posedge clk);
      #1;
      drive(4'b1000, 1'b0, 32'h0);
      #1;
      rst = 1'b0;
      #1;
      check("rst_mid_ctl",  64'(get_ctl()), 64'(13'h0));
      check("rst_mid_addr", 64'(hz.redirect_addr), 64'h0);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("wd_after_rst0", 64'(get_ctl()), 64'(ctl(S_MEM, B_WB, 0, 0, 0)));
      for (int k = 1; k < 4; k++) begin
         cyc(4'b1000, 1'b0, 32'h0);
         check($sformatf("wd_after_rst%0d", k), 64'(get_ctl()),
               64'(ctl(S_MEM, B_WB, 0, 0, (k == 3))));
      end

      // Reset during EXC_WAIT discards the pending redirect.
      cyc(4'b0000, 1'b0, 32'h0);
      check("exr_idle", 64'(get_ctl()), 64'(13'h0));
      cyc(4'b1000, 1'b1, 32'h00000300);
      check("exr_take", 64'(get_ctl()), 64'(ctl(S_MEM, B_WB, 0, 0, 0)));
      cyc(4'b1000, 1'b0, 32'h0);
      check("exr_wait", 64'(get_ctl()), 64'(ctl(S_MEM, B_WB, 0, 0, 0)));
      @(posedge clk);
      #1;
      drive(4'b0000, 1'b0, 32'h0);
      #1;
      rst = 1'b0;
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("exr_run", 64'(get_ctl()), 64'(13'h0));
      cyc(4'b0000, 1'b0, 32'h0);
      check("exr_noflush_ctl",  64'(get_ctl()), 64'(13'h0));
      check("exr_noflush_addr", 64'(hz.redirect_addr), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequential replacement for the combinational stall-only pipeline controller in the 5-stage MIPS core. It merges stall requests from IF/ID/EX/MEM into per-stage stall and bubble controls. It sequences exception flushes and the PC redirect, deferring them across memory-bus waits and fetch waits. A watchdog flags pathological stalls. It sits beside the pipeline registers and drives their stall/flush inputs and the PC mux.

Parameters:
ADDR_WIDTH, 32, width of PC/redirect target
TO_WIDTH, 16, width of consecutive-stall counter
STALL_TIMEOUT, 1024, consecutive stall cycles before stall_timeout pulses; range 1..2^TO_WIDTH-1

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
request_from_if  in  1  fetch bus wait
request_from_id  in  1  load-use hazard
request_from_ex  in  1  mult/div busy
request_from_mem  in  1  data bus wait
exc_valid  in  1  exception committed in MEM this cycle
exc_target  in  ADDR_WIDTH  handler address, valid with exc_valid
stall_pc, stall_if, stall_id, stall_ex, stall_mem, stall_wb  out  1 each  hold stage register
bubble_id, bubble_ex, bubble_mem, bubble_wb  out  1 each  load NOP into stage input register
flush_all  out  1  kill IF..MEM contents
redirect_valid  out  1  PC mux selects redirect_addr
redirect_addr  out  ADDR_WIDTH  redirect target
stall_timeout  out  1  one-cycle watchdog pulse

Behaviour:
- Reset (rst low, async): state=RUN, counter=0, redirect_addr=0. All outputs 0.
- Stall merge (combinational, RUN state): highest requesting stage k wins; priority MEM>EX>ID>IF.
  - Stage k and all earlier stages stall; stage k+1 gets a bubble.
  - MEM: stall pc..mem, bubble_wb.
  - EX: stall pc..ex, bubble_mem.
  - ID: stall pc..id, bubble_ex.
  - IF: stall pc,if, bubble_id.
  - stall_wb is always 0.
- FSM states: RUN, EXC_WAIT, FLUSH, REDIR_HOLD.
  - RUN, exc_valid and !request_from_mem: latch exc_target, go to FLUSH.
  - RUN, exc_valid and request_from_mem: latch exc_target, go to EXC_WAIT.
  - EXC_WAIT: stall pc..mem and bubble_wb (the stall merge result for a MEM request), whatever the inputs. Go to FLUSH on the first cycle with request_from_mem=0.
  - FLUSH: exactly one cycle. flush_all=1, redirect_valid=1, all stalls 0.
    - Next state REDIR_HOLD if request_from_if=1, otherwise RUN.
  - REDIR_HOLD: redirect_valid=1, stall_if=1, stall_pc=0. Return to RUN when request_from_if=0, with redirect_valid still 1 in that cycle.
- Inputs ignored:
  - exc_valid outside RUN is ignored; the instruction is killed or is the same held one.
  - Stall requests outside RUN are ignored, except as stated for each state.
- Simultaneous exc_valid and a stall request in RUN: the exception path wins. The current cycle still outputs the merged stall.
- Watchdog:
  - Counter increments each cycle any stall_pc=1.
  - Counter clears when stall_pc=0.
  - stall_timeout pulses for one cycle when the counter reaches STALL_TIMEOUT, then the counter saturates with no further pulses until it clears.
- Reset mid-sequence: immediate return to RUN; any pending redirect is discarded.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_count[31:0].
  - perf_stall_cycles increments on cycles with stall_pc=1.
  - perf_flush_count increments on each FLUSH entry.
  - Both wrap at 2^32 and clear on reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header (alongside bus.v defines):
  - FSM state encodings: 2-bit, RUN=0, EXC_WAIT=1, FLUSH=2, REDIR_HOLD=3.
  - Stall vector constants: STALL_IF=6'b000011, STALL_ID=6'b000111, STALL_EX=6'b001111, STALL_MEM=6'b011111.
- One sub-module, stall_watchdog: counter, compare, saturation and pulse, parameterised by TO_WIDTH and STALL_TIMEOUT.

Test Plan:
- request_from_id=1 for 1 cycle in RUN -> {stall_pc,stall_if,stall_id}=111 and bubble_ex=1 that cycle; others 0.
- request_from_ex and request_from_if both high -> stall pc..ex, bubble_mem=1, bubble_id=0.
- exc_valid with exc_target=0xBFC00380, all requests low -> next cycle flush_all=1, redirect_valid=1, redirect_addr=0xBFC00380; following cycle all outputs 0.
- exc_valid while request_from_mem high for 3 more cycles -> stall pc..mem held 3 cycles, then one FLUSH cycle; a second exc_valid during the wait is ignored.
- FLUSH with request_from_if=1 for 2 cycles -> redirect_valid high for 3 cycles total; stall_if=1 during the hold; then RUN.
- STALL_TIMEOUT=4, request_from_mem held 10 cycles -> stall_timeout single pulse on the 4th stall cycle; rst low mid-stall -> all outputs 0 immediately.
